audioqsys_key_input: RTL



---
 rtl/audioqsys_key_input.sv | 135 +++++++++++++
 1 files changed

// File: rtl/audioqsys_key_input.sv
// Avalon-MM input PIO for keys/switches: 2-flop synchroniser, per-bit debounce,
// edge capture with write-1-to-clear, and a masked level interrupt.
module audioqsys_key_input #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d_reg;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] irq_mask_next;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] edge_capture_next;
    logic [WIDTH-1:0] clear;
    logic [31:0]      readdata_next;
    logic             irq_next;
    logic             write_en;
    logic             unused_bits;

    // read strobe is informational and upper writedata bits have no storage
    assign unused_bits = ^{read, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync_reg  <= '0;
            deb_d_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync_reg  <= sync1_reg;
            deb_d_reg <= deb;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          deb_reg;
            logic          deb_next;

            // Counter only runs while sync disagrees with deb; it can never pass CNT_LAST.
            always_comb begin
                cnt_next = '0;
                deb_next = deb_reg;
                if (sync_reg[gi] != deb_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        deb_next = sync_reg[gi];
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                    deb_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    deb_reg <= deb_next;
                end
            end

            assign deb[gi] = deb_reg;
        end
    endgenerate

    assign rise = deb & ~deb_d_reg;
    assign fall = ~deb & deb_d_reg;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_evt = rise;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_evt = fall;
        end else begin : g_any
            assign edge_evt = rise | fall;
        end
    endgenerate

    assign write_en = chipselect & ~write_n;
    assign clear    = (write_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as its clear keeps the bit set.
    assign edge_capture_next = (edge_capture_reg & ~clear) | edge_evt;
    assign irq_mask_next     = (write_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_reg;
    assign irq_next          = |(edge_capture_reg & irq_mask_reg);

    always_comb begin
        readdata_next = '0;
        case (address)
            2'd0:    readdata_next[WIDTH-1:0] = deb;
            2'd2:    readdata_next[WIDTH-1:0] = irq_mask_reg;
            2'd3:    readdata_next[WIDTH-1:0] = edge_capture_reg;
            default: readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_reg <= '0;
            irq_mask_reg     <= '0;
            irq              <= 1'b0;
            readdata         <= '0;
        end else begin
            edge_capture_reg <= edge_capture_next;
            irq_mask_reg     <= irq_mask_next;
            irq              <= irq_next;
            readdata         <= readdata_next;
        end
    end

endmodule
